// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS receive checker with lock detect and BER counters.
// Define PRBS_CHK_RELOCK_CNT_EN to add the relock_cnt output.
module prbs_checker #(
    parameter int POLY_LENGTH = 7,
    parameter int POLY_TAP    = 6,
    parameter int INV_PATTERN = 0,
    parameter int LOCK_CNT    = 32,
    parameter int LOSS_CNT    = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_valid,
    input  logic             data_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
`ifdef PRBS_CHK_RELOCK_CNT_EN
    ,
    output logic [7:0]       relock_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, SEED, SYNC, LOCKED} state_t;
    state_t state, state_nxt;
    logic [POLY_LENGTH-1:0] s, s_nxt;
    // one counter serves as seed count, match count or consecutive-error count depending on state
    logic [7:0] cnt, cnt_nxt;
    logic b, p, err, lost, chk;
    assign b = data_in ^ (INV_PATTERN != 0);
    assign p = s[POLY_LENGTH-1] ^ s[POLY_TAP-1];
    assign locked = (state == LOCKED);
    always_comb begin
        state_nxt = state;
        s_nxt = s;
        cnt_nxt = cnt;
        err = 1'b0;
        lost = 1'b0;
        chk = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            s_nxt = '0;
            cnt_nxt = '0;
        end else if (!data_valid) begin
            state_nxt = (state == IDLE) ? SEED : state;
        end else if (state == IDLE || state == SEED) begin
            s_nxt = {s[POLY_LENGTH-2:0], b};
            state_nxt = (cnt == 8'(POLY_LENGTH - 1)) ? SYNC : SEED;
            cnt_nxt = (cnt == 8'(POLY_LENGTH - 1)) ? 8'd0 : cnt + 8'd1;
        end else if (state == SYNC) begin
            s_nxt = {s[POLY_LENGTH-2:0], b};
            if (b != p) begin
                state_nxt = SEED;
                cnt_nxt = '0;
            end else if (cnt == 8'(LOCK_CNT - 1)) begin
                // an all-zero register only ever predicts zeros, so refuse to lock on it
                state_nxt = (s == '0) ? SEED : LOCKED;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + 8'd1;
            end
        end else begin
            s_nxt = {s[POLY_LENGTH-2:0], p};
            chk = 1'b1;
            err = (b != p);
            lost = err && (cnt == 8'(LOSS_CNT - 1));
            state_nxt = lost ? SEED : LOCKED;
            cnt_nxt = (!err || lost) ? 8'd0 : cnt + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s <= '0;
            cnt <= '0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            err_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            s <= s_nxt;
            cnt <= cnt_nxt;
            err_pulse <= err;
            lock_lost <= lost;
            if (clr_cnt) begin
                err_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                if (err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                if (chk && bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end
`ifdef PRBS_CHK_RELOCK_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) relock_cnt <= '0;
        else if (lost && relock_cnt != 8'hff) relock_cnt <= relock_cnt + 8'd1;
    end
`endif
endmodule
